// File: rtl/iso_lane_deframer.sv
// Single-lane isochronous deframer: parses BS/SR, VB-ID/Mvid/Maud, BE, FS/FE stuffing and
// SS/SE secondary packets, and recovers pixel bytes, secondary bytes and line timing.
module iso_lane_deframer #(
    parameter logic [7:0] BS_SYM = 8'hBC,
    parameter logic [7:0] BE_SYM = 8'hFB,
    parameter logic [7:0] SR_SYM = 8'h1C,
    parameter logic [7:0] FS_SYM = 8'hFE,
    parameter logic [7:0] FE_SYM = 8'hF7,
    parameter logic [7:0] SS_SYM = 8'h5C,
    parameter logic [7:0] SE_SYM = 8'hFD,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       iso_symbols,
    input  logic             iso_ctrl_flag,
    output logic [7:0]       pix_byte,
    output logic             pix_vld,
    output logic [7:0]       sec_byte,
    output logic             sec_vld,
    output logic [7:0]       vbid,
    output logic [7:0]       mvid,
    output logic [7:0]       maud,
    output logic             vbid_vld,
    output logic [CNT_W-1:0] line_bytes,
    output logic             line_done,
    output logic             sr_seen,
    output logic             locked,
    output logic             err
);

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_VBID   = 3'd1,
        S_MVID   = 3'd2,
        S_MAUD   = 3'd3,
        S_BLANK  = 3'd4,
        S_SEC    = 3'd5,
        S_ACTIVE = 3'd6,
        S_STUFF  = 3'd7
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [7:0]       r_pix_byte, w_pix_byte_nxt;
    logic             r_pix_vld, w_pix_vld_nxt;
    logic [7:0]       r_sec_byte, w_sec_byte_nxt;
    logic             r_sec_vld, w_sec_vld_nxt;
    logic [7:0]       r_vbid, w_vbid_nxt;
    logic [7:0]       r_mvid, w_mvid_nxt;
    logic [7:0]       r_maud, w_maud_nxt;
    logic             r_vbid_vld, w_vbid_vld_nxt;
    logic [CNT_W-1:0] r_line_bytes, w_line_bytes_nxt;
    logic             r_line_done, w_line_done_nxt;
    logic             r_sr_seen;
    logic             r_locked, w_locked_nxt;
    logic             r_err, w_err_nxt;
    logic             w_proto_err;

    logic w_is_sr, w_is_bs, w_is_be, w_is_fs, w_is_fe, w_is_ss, w_is_se;

    // SR is a scrambler-reset substitute for BS and is otherwise handled identically.
    assign w_is_sr   = iso_ctrl_flag && (iso_symbols == SR_SYM);
    assign w_is_bs   = iso_ctrl_flag && ((iso_symbols == BS_SYM) || (iso_symbols == SR_SYM));
    assign w_is_be   = iso_ctrl_flag && (iso_symbols == BE_SYM);
    assign w_is_fs   = iso_ctrl_flag && (iso_symbols == FS_SYM);
    assign w_is_fe   = iso_ctrl_flag && (iso_symbols == FE_SYM);
    assign w_is_ss   = iso_ctrl_flag && (iso_symbols == SS_SYM);
    assign w_is_se   = iso_ctrl_flag && (iso_symbols == SE_SYM);
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : (r_cnt + CNT_W'(1));

    // Next-state and next-output decode for every received symbol.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pix_byte_nxt   = r_pix_byte;
        w_pix_vld_nxt    = 1'b0;
        w_sec_byte_nxt   = r_sec_byte;
        w_sec_vld_nxt    = 1'b0;
        w_vbid_nxt       = r_vbid;
        w_mvid_nxt       = r_mvid;
        w_maud_nxt       = r_maud;
        w_vbid_vld_nxt   = 1'b0;
        w_line_bytes_nxt = r_line_bytes;
        w_line_done_nxt  = 1'b0;
        w_locked_nxt     = r_locked;
        w_err_nxt        = 1'b0;
        w_proto_err      = 1'b0;

        case (r_state)
            S_HUNT: begin
                if (w_is_bs) begin
                    w_state_nxt  = S_VBID;
                    w_locked_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_HUNT;
                end
            end
            S_VBID: begin
                if (iso_ctrl_flag) begin
                    w_proto_err = 1'b1;
                end else begin
                    w_vbid_nxt  = iso_symbols;
                    w_state_nxt = S_MVID;
                end
            end
            S_MVID: begin
                if (iso_ctrl_flag) begin
                    w_proto_err = 1'b1;
                end else begin
                    w_mvid_nxt  = iso_symbols;
                    w_state_nxt = S_MAUD;
                end
            end
            S_MAUD: begin
                if (iso_ctrl_flag) begin
                    w_proto_err = 1'b1;
                end else begin
                    w_maud_nxt     = iso_symbols;
                    w_vbid_vld_nxt = 1'b1;
                    w_state_nxt    = S_BLANK;
                end
            end
            S_BLANK: begin
                if (!iso_ctrl_flag) begin
                    w_state_nxt = S_BLANK;
                end else if (w_is_ss) begin
                    w_state_nxt = S_SEC;
                end else if (w_is_be) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (w_is_bs) begin
                    w_state_nxt = S_VBID;
                end else begin
                    w_proto_err = 1'b1;
                end
            end
            S_SEC: begin
                if (!iso_ctrl_flag) begin
                    w_sec_byte_nxt = iso_symbols;
                    w_sec_vld_nxt  = 1'b1;
                end else if (w_is_se) begin
                    w_state_nxt = S_BLANK;
                end else begin
                    w_proto_err = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!iso_ctrl_flag) begin
                    w_pix_byte_nxt = iso_symbols;
                    w_pix_vld_nxt  = 1'b1;
                    w_cnt_nxt      = w_cnt_inc;
                end else if (w_is_fs) begin
                    w_state_nxt = S_STUFF;
                end else if (w_is_bs) begin
                    w_line_done_nxt  = 1'b1;
                    w_line_bytes_nxt = r_cnt;
                    w_state_nxt      = S_VBID;
                end else begin
                    w_proto_err = 1'b1;
                end
            end
            S_STUFF: begin
                if (!iso_ctrl_flag) begin
                    w_state_nxt = S_STUFF;
                end else if (w_is_fe) begin
                    w_state_nxt = S_ACTIVE;
                end else begin
                    w_proto_err = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase

        // A protocol error drops lock and discards any pending line.
        if (w_proto_err) begin
            w_err_nxt       = 1'b1;
            w_locked_nxt    = 1'b0;
            w_line_done_nxt = 1'b0;
            w_state_nxt     = S_HUNT;
        end else begin
            w_err_nxt = 1'b0;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_cnt        <= {CNT_W{1'b0}};
            r_pix_byte   <= 8'h00;
            r_pix_vld    <= 1'b0;
            r_sec_byte   <= 8'h00;
            r_sec_vld    <= 1'b0;
            r_vbid       <= 8'h00;
            r_mvid       <= 8'h00;
            r_maud       <= 8'h00;
            r_vbid_vld   <= 1'b0;
            r_line_bytes <= {CNT_W{1'b0}};
            r_line_done  <= 1'b0;
            r_sr_seen    <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pix_byte   <= w_pix_byte_nxt;
            r_pix_vld    <= w_pix_vld_nxt;
            r_sec_byte   <= w_sec_byte_nxt;
            r_sec_vld    <= w_sec_vld_nxt;
            r_vbid       <= w_vbid_nxt;
            r_mvid       <= w_mvid_nxt;
            r_maud       <= w_maud_nxt;
            r_vbid_vld   <= w_vbid_vld_nxt;
            r_line_bytes <= w_line_bytes_nxt;
            r_line_done  <= w_line_done_nxt;
            r_sr_seen    <= w_is_sr;
            r_locked     <= w_locked_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign pix_byte   = r_pix_byte;
    assign pix_vld    = r_pix_vld;
    assign sec_byte   = r_sec_byte;
    assign sec_vld    = r_sec_vld;
    assign vbid       = r_vbid;
    assign mvid       = r_mvid;
    assign maud       = r_maud;
    assign vbid_vld   = r_vbid_vld;
    assign line_bytes = r_line_bytes;
    assign line_done  = r_line_done;
    assign sr_seen    = r_sr_seen;
    assign locked     = r_locked;
    assign err        = r_err;

endmodule

// File: tb/tb_iso_lane_deframer.sv
// Directed bench for iso_lane_deframer: a vector table for blanking/secondary/error cases
// plus hand-written line sequences for long lines, stuffing, SR and mid-line reset.
module tb_iso_lane_deframer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  iso_symbols;
    logic        iso_ctrl_flag;
    logic [7:0]  pix_byte, sec_byte, vbid, mvid, maud;
    logic        pix_vld, sec_vld, vbid_vld, line_done, sr_seen, locked, err;
    logic [15:0] line_bytes;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        ctrl;
        logic [7:0]  sym;
        logic        pv;
        logic        sv;
        logic        vv;
        logic        ld;
        logic [15:0] lb;
        logic        er;
        logic        lk;
        logic        sr;
    } vec_t;

    vec_t vq[$];

    iso_lane_deframer dut (
        .clk(clk), .rst(rst), .iso_symbols(iso_symbols), .iso_ctrl_flag(iso_ctrl_flag),
        .pix_byte(pix_byte), .pix_vld(pix_vld), .sec_byte(sec_byte), .sec_vld(sec_vld),
        .vbid(vbid), .mvid(mvid), .maud(maud), .vbid_vld(vbid_vld),
        .line_bytes(line_bytes), .line_done(line_done), .sr_seen(sr_seen),
        .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [7:0] s);
        @(negedge clk);
        iso_ctrl_flag = c;
        iso_symbols   = s;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic c, input logic [7:0] s, input logic pv,
                                input logic sv, input logic vv, input logic ld,
                                input logic [15:0] lb, input logic er, input logic lk);
        vec_t v;
        v.ctrl = c; v.sym = s; v.pv = pv; v.sv = sv; v.vv = vv;
        v.ld = ld; v.lb = lb; v.er = er; v.lk = lk;
        v.sr = c && (s == 8'h1C);
        return v;
    endfunction

    // From VBID state: header bytes, BE, n data bytes, closing BS or SR.
    task automatic run_line(input logic [7:0] vb, input logic [7:0] mv, input logic [7:0] ma,
                            input int n, input bit close_sr);
        int np = 0;
        int nv = 0;
        drive(1'b0, vb); if (vbid_vld) nv++;
        drive(1'b0, mv); if (vbid_vld) nv++;
        drive(1'b0, ma); if (vbid_vld) nv++;
        chk("hdr vbid", vbid, vb);
        chk("hdr mvid", mvid, mv);
        chk("hdr maud", maud, ma);
        drive(1'b1, 8'hFB);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 8'(8'h40 + i));
            if (pix_vld) np++;
            chk("line pix_byte", pix_byte, 8'(8'h40 + i));
        end
        drive(1'b1, close_sr ? 8'h1C : 8'hBC);
        chk("line pix_vld count", np, n);
        chk("line vbid_vld count", nv, 1);
        chk("line line_done", line_done, 1);
        chk("line line_bytes", line_bytes, n);
        chk("line sr_seen", sr_seen, close_sr);
        chk("line err", err, 0);
        chk("line locked", locked, 1);
    endtask

    initial begin
        int np;
        int nld;
        rst = 1'b1;
        iso_ctrl_flag = 1'b0;
        iso_symbols = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {pix_byte, pix_vld, sec_byte, sec_vld, vbid_vld, line_done}, 0);
        chk("reset hdr", {vbid, mvid, maud}, 0);
        chk("reset misc", {line_bytes, sr_seen, locked, err}, 0);
        @(negedge clk);
        rst = 1'b0;

        // HUNT ignores data and non-BS control codes without error.
        drive(1'b0, 8'h12);
        drive(1'b1, 8'hFB);
        chk("hunt no err", err, 0);
        chk("hunt unlocked", locked, 0);
        drive(1'b1, 8'hBC);
        chk("bs locks", locked, 1);
        chk("bs no sr_seen", sr_seen, 0);

        // Test 1 and SR-closed test 4.
        run_line(8'h01, 8'h22, 8'h33, 48, 1'b0);
        run_line(8'h02, 8'h44, 8'h55, 48, 1'b1);

        // Test 2: stuffing inside ACTIVE.
        np = 0;
        drive(1'b0, 8'h01); drive(1'b0, 8'h22); drive(1'b0, 8'h33);
        drive(1'b1, 8'hFB);
        for (int i = 0; i < 10; i++) begin drive(1'b0, 8'(i)); if (pix_vld) np++; end
        drive(1'b1, 8'hFE);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'hEE);
            chk("stuff pix_vld", pix_vld, 0);
        end
        drive(1'b1, 8'hF7);
        for (int i = 0; i < 10; i++) begin drive(1'b0, 8'(i + 10)); if (pix_vld) np++; end
        drive(1'b1, 8'hBC);
        chk("stuff pix count", np, 20);
        chk("stuff line_done", line_done, 1);
        chk("stuff line_bytes", line_bytes, 20);

        // Vector table: secondary packet, short lines, protocol errors.
        vq.push_back(mk(0, 8'h01, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h22, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h33, 0,0,1,0,0,0,1));
        vq.push_back(mk(0, 8'h55, 0,0,0,0,0,0,1));
        vq.push_back(mk(1, 8'h5C, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'hA0, 0,1,0,0,0,0,1));
        vq.push_back(mk(0, 8'hA1, 0,1,0,0,0,0,1));
        vq.push_back(mk(0, 8'hA2, 0,1,0,0,0,0,1));
        vq.push_back(mk(0, 8'hA3, 0,1,0,0,0,0,1));
        vq.push_back(mk(1, 8'hFD, 0,0,0,0,0,0,1));
        vq.push_back(mk(1, 8'hFB, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h77, 1,0,0,0,0,0,1));
        vq.push_back(mk(1, 8'hBC, 0,0,0,1,1,0,1));
        vq.push_back(mk(0, 8'h01, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h22, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h33, 0,0,1,0,0,0,1));
        vq.push_back(mk(1, 8'hFB, 0,0,0,0,0,0,1));
        vq.push_back(mk(1, 8'hBC, 0,0,0,1,0,0,1));
        vq.push_back(mk(0, 8'h01, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h22, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h33, 0,0,1,0,0,0,1));
        vq.push_back(mk(1, 8'hFB, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h10, 1,0,0,0,0,0,1));
        vq.push_back(mk(1, 8'hFE, 0,0,0,0,0,0,1));
        vq.push_back(mk(1, 8'hFB, 0,0,0,0,0,1,0));
        vq.push_back(mk(0, 8'h99, 0,0,0,0,0,0,0));
        vq.push_back(mk(1, 8'hFB, 0,0,0,0,0,0,0));
        vq.push_back(mk(1, 8'h1C, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h01, 0,0,0,0,0,0,1));
        vq.push_back(mk(1, 8'hFB, 0,0,0,0,0,1,0));
        vq.push_back(mk(0, 8'h22, 0,0,0,0,0,0,0));
        vq.push_back(mk(1, 8'hBC, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h01, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h22, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h33, 0,0,1,0,0,0,1));
        vq.push_back(mk(1, 8'hFB, 0,0,0,0,0,0,1));
        vq.push_back(mk(0, 8'h05, 1,0,0,0,0,0,1));
        vq.push_back(mk(1, 8'hAA, 0,0,0,0,0,1,0));
        vq.push_back(mk(0, 8'h06, 0,0,0,0,0,0,0));

        foreach (vq[i]) begin
            drive(vq[i].ctrl, vq[i].sym);
            chk($sformatf("v%0d pix_vld", i), pix_vld, vq[i].pv);
            if (vq[i].pv) chk($sformatf("v%0d pix_byte", i), pix_byte, vq[i].sym);
            chk($sformatf("v%0d sec_vld", i), sec_vld, vq[i].sv);
            if (vq[i].sv) chk($sformatf("v%0d sec_byte", i), sec_byte, vq[i].sym);
            chk($sformatf("v%0d vbid_vld", i), vbid_vld, vq[i].vv);
            chk($sformatf("v%0d line_done", i), line_done, vq[i].ld);
            if (vq[i].ld) chk($sformatf("v%0d line_bytes", i), line_bytes, vq[i].lb);
            chk($sformatf("v%0d err", i), err, vq[i].er);
            chk($sformatf("v%0d locked", i), locked, vq[i].lk);
            chk($sformatf("v%0d sr_seen", i), sr_seen, vq[i].sr);
        end

        // Test 6: reset in the middle of an active line.
        drive(1'b1, 8'hBC);
        drive(1'b0, 8'h01); drive(1'b0, 8'h22); drive(1'b0, 8'h33);
        drive(1'b1, 8'hFB);
        drive(1'b0, 8'h61); drive(1'b0, 8'h62); drive(1'b0, 8'h63);
        chk("pre-reset pix_vld", pix_vld, 1);
        @(negedge clk);
        iso_ctrl_flag = 1'b0;
        iso_symbols = 8'h64;
        rst = 1'b1;
        #1;
        chk("midrst outputs", {pix_byte, pix_vld, sec_byte, sec_vld, vbid_vld, line_done}, 0);
        chk("midrst hdr", {vbid, mvid, maud}, 0);
        chk("midrst misc", {line_bytes, sr_seen, locked, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        nld = 0;
        drive(1'b0, 8'h11); if (line_done) nld++;
        drive(1'b1, 8'hFB); if (line_done) nld++;
        drive(1'b0, 8'h12); if (line_done || pix_vld) nld++;
        drive(1'b1, 8'hBC); if (line_done) nld++;
        chk("post-reset no line_done", nld, 0);
        chk("post-reset relock", locked, 1);
        run_line(8'h07, 8'h08, 8'h09, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
